// File: rtl/vram_scanout.sv
// vram_scanout
//   VGA display back end for a 128x64, 2-bit-per-pixel VRAM. Generates
//   640x480@60 timing on the pixel clock, fetches one VRAM pixel per clock,
//   maps it through a 4-entry RGB444 palette and drives registered sync,
//   data-enable and colour outputs. Also emits a once-per-frame pulse at the
//   start of vertical blanking for the CPU's 60 Hz timers.
//
// Ports
//   clk            in   pixel clock, all logic on posedge
//   reset_n        in   asynchronous active-low reset
//   vram_rd_hpos   out  VRAM column address (combinational from counters)
//   vram_rd_vpos   out  VRAM row address (combinational from counters)
//   vram_rd_pixel  in   VRAM read data, valid one clock after the address
//   hsync, vsync   out  active-low syncs
//   de             out  high during the visible area
//   rgb            out  {R,G,B} 4 bits each, zero while blanked
//   frame_start    out  one-clock pulse at the first blanking line
//
// Counter state (h,v) reaches every output exactly two clocks later.
module vram_scanout #(
    parameter int          H_ACTIVE   = 640,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BP       = 48,
    parameter int          V_ACTIVE   = 480,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 33,
    parameter int          SCALE_LOG2 = 2,
    parameter int          X_OFFSET   = 64,
    parameter int          Y_OFFSET   = 112,
    parameter logic [11:0] PAL0       = 12'h000,
    parameter logic [11:0] PAL1       = 12'h555,
    parameter logic [11:0] PAL2       = 12'hAAA,
    parameter logic [11:0] PAL3       = 12'hFFF,
    parameter logic [11:0] BORDER     = 12'h111
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [6:0]  vram_rd_hpos,
    output logic [5:0]  vram_rd_vpos,
    input  logic [1:0]  vram_rd_pixel,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [11:0] rgb,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] X_BEG      = HW'(X_OFFSET);
    localparam logic [HW-1:0] X_END      = HW'(X_OFFSET + (128 << SCALE_LOG2));

    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] Y_BEG      = VW'(Y_OFFSET);
    localparam logic [VW-1:0] Y_END      = VW'(Y_OFFSET + (64 << SCALE_LOG2));

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    // stage 0 decode
    logic visible_0, in_win_0, hs_0, vs_0, fs_0;
    // stage 1, aligned with the outstanding VRAM read
    logic visible_1, in_win_1, hs_1, vs_1, fs_1;
    logic [11:0] pal_color;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    assign visible_0 = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
    assign in_win_0  = (h_cnt >= X_BEG) && (h_cnt < X_END) &&
                       (v_cnt >= Y_BEG) && (v_cnt < Y_END);
    assign hs_0      = !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
    assign vs_0      = !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));
    assign fs_0      = (h_cnt == '0) && (v_cnt == V_VIS_END);

    // Subtraction wraps at counter width outside the window; those reads are
    // discarded, so the wrapped address is harmless.
    assign vram_rd_hpos = 7'((h_cnt - X_BEG) >> SCALE_LOG2);
    assign vram_rd_vpos = 6'((v_cnt - Y_BEG) >> SCALE_LOG2);

    // Syncs reset to their inactive level so no stray pulse leaves the
    // pipeline right after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            visible_1 <= 1'b0;
            in_win_1  <= 1'b0;
            hs_1      <= 1'b1;
            vs_1      <= 1'b1;
            fs_1      <= 1'b0;
        end else begin
            visible_1 <= visible_0;
            in_win_1  <= in_win_0;
            hs_1      <= hs_0;
            vs_1      <= vs_0;
            fs_1      <= fs_0;
        end
    end

    always_comb begin
        pal_color = PAL0;
        case (vram_rd_pixel)
            2'd0:    pal_color = PAL0;
            2'd1:    pal_color = PAL1;
            2'd2:    pal_color = PAL2;
            default: pal_color = PAL3;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            de          <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
            rgb         <= '0;
        end else begin
            de          <= visible_1;
            hsync       <= hs_1;
            vsync       <= vs_1;
            frame_start <= fs_1;
            if (!visible_1)
                rgb <= '0;
            else if (in_win_1)
                rgb <= pal_color;
            else
                rgb <= BORDER;
        end
    end

endmodule

// File: tb/tb_vram_scanout.sv
`timescale 1ns/1ps
module tb_vram_scanout;

    // Two instances: full-size 640x480 timing for line and reset behaviour,
    // and a reduced geometry (SCALE 2x, 288x144 total) whose whole frame fits
    // in a short run, for window, palette, vertical and frame checks.
    localparam int HT_F = 800;
    localparam int HT_M = 288;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic        rst_f, rst_m;
    logic [6:0]  hpos_f, hpos_m;
    logic [5:0]  vpos_f, vpos_m;
    logic [1:0]  pix_f, pix_m;
    logic        hsync_f, vsync_f, de_f, fs_f;
    logic        hsync_m, vsync_m, de_m, fs_m;
    logic [11:0] rgb_f, rgb_m;

    vram_scanout dut_f (
        .clk(clk), .reset_n(rst_f),
        .vram_rd_hpos(hpos_f), .vram_rd_vpos(vpos_f), .vram_rd_pixel(pix_f),
        .hsync(hsync_f), .vsync(vsync_f), .de(de_f), .rgb(rgb_f),
        .frame_start(fs_f)
    );

    vram_scanout #(
        .H_ACTIVE(272), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(136), .V_FP(3), .V_SYNC(2), .V_BP(3),
        .SCALE_LOG2(1), .X_OFFSET(8), .Y_OFFSET(4)
    ) dut_m (
        .clk(clk), .reset_n(rst_m),
        .vram_rd_hpos(hpos_m), .vram_rd_vpos(vpos_m), .vram_rd_pixel(pix_m),
        .hsync(hsync_m), .vsync(vsync_m), .de(de_m), .rgb(rgb_m),
        .frame_start(fs_m)
    );

    // VRAM models: one-clock read latency
    function automatic logic [1:0] vram_m(logic [6:0] x, logic [5:0] y);
        if (x == 7'd5 && y == 6'd3)        return 2'd2;
        else if (x == 7'd0 && y == 6'd0)   return 2'd3;
        else if (x == 7'd127 && y == 6'd63) return 2'd1;
        else                               return 2'd0;
    endfunction

    always @(posedge clk) pix_f <= 2'd3;
    always @(posedge clk) pix_m <= vram_m(hpos_m, vpos_m);

    // k = number of rising edges since reset release
    int k_f, k_m;
    always @(posedge clk or negedge rst_f) if (!rst_f) k_f <= 0; else k_f <= k_f + 1;
    always @(posedge clk or negedge rst_m) if (!rst_m) k_m <= 0; else k_m <= k_m + 1;

    typedef struct {
        int          k;
        bit          is_addr;
        bit          chk_v;
        logic [6:0]  hp;
        logic [5:0]  vp;
        logic        de, hs, vs, fs;
        logic [11:0] rgb;
        string       name;
    } exp_t;

    exp_t q_f[$];
    exp_t q_m[$];
    int tests = 0;
    int fails = 0;

    function automatic exp_t e_out(int k, logic de, logic hs, logic vs, logic fs,
                                   logic [11:0] rgb, string name);
        exp_t e;
        e.k = k; e.is_addr = 1'b0; e.chk_v = 1'b0; e.hp = '0; e.vp = '0;
        e.de = de; e.hs = hs; e.vs = vs; e.fs = fs; e.rgb = rgb; e.name = name;
        return e;
    endfunction

    function automatic exp_t e_addr(int k, logic [6:0] hp, logic [5:0] vp, bit chk_v,
                                    string name);
        exp_t e;
        e = e_out(k, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, name);
        e.is_addr = 1'b1; e.chk_v = chk_v; e.hp = hp; e.vp = vp;
        return e;
    endfunction

    task automatic push_f(exp_t e);
        int i;
        i = q_f.size();
        while (i > 0 && q_f[i-1].k > e.k) i--;
        q_f.insert(i, e);
    endtask

    task automatic push_m(exp_t e);
        int i;
        i = q_m.size();
        while (i > 0 && q_m[i-1].k > e.k) i--;
        q_m.insert(i, e);
    endtask

    // Output of counter state (h,v) is sampled after edge v*HT+h+2;
    // the combinational address for (h,v) after edge v*HT+h.
    task automatic of(int h, int v, logic de, logic hs, logic vs, logic fs,
                      logic [11:0] rgb, string n);
        push_f(e_out(v*HT_F + h + 2, de, hs, vs, fs, rgb, n));
    endtask
    task automatic om(int h, int v, logic de, logic hs, logic vs, logic fs,
                      logic [11:0] rgb, string n);
        push_m(e_out(v*HT_M + h + 2, de, hs, vs, fs, rgb, n));
    endtask
    task automatic af(int h, logic [6:0] hp, string n);
        push_f(e_addr(h, hp, 6'd0, 1'b0, n));
    endtask
    task automatic am(int h, int v, logic [6:0] hp, logic [5:0] vp, string n);
        push_m(e_addr(v*HT_M + h, hp, vp, 1'b1, n));
    endtask

    task automatic check_entry(exp_t e, logic [6:0] hp, logic [5:0] vp, logic de,
                               logic hs, logic vs, logic fs, logic [11:0] rgb);
        tests++;
        if (e.is_addr) begin
            if (hp !== e.hp || (e.chk_v && vp !== e.vp)) begin
                fails++;
                $display("FAIL %s: got hpos=%0d vpos=%0d, expected hpos=%0d vpos=%0d%s",
                         e.name, hp, vp, e.hp, e.vp, e.chk_v ? "" : " (vpos unchecked)");
            end
        end else if ({de, hs, vs, fs, rgb} !== {e.de, e.hs, e.vs, e.fs, e.rgb}) begin
            fails++;
            $display("FAIL %s: got de=%b hs=%b vs=%b fs=%b rgb=%h, expected de=%b hs=%b vs=%b fs=%b rgb=%h",
                     e.name, de, hs, vs, fs, rgb, e.de, e.hs, e.vs, e.fs, e.rgb);
        end
    endtask

    task automatic check_int(string name, int got, int expv);
        tests++;
        if (got != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    // Monitors: pop every expectation whose sample slot has arrived
    exp_t mon_ef, mon_em;
    always @(negedge clk) begin
        if (rst_f === 1'b1) begin
            while (q_f.size() > 0 && q_f[0].k <= k_f) begin
                mon_ef = q_f.pop_front();
                if (mon_ef.k < k_f) begin
                    tests++; fails++;
                    $display("FAIL %s: slot %0d missed (now %0d)", mon_ef.name, mon_ef.k, k_f);
                end else
                    check_entry(mon_ef, hpos_f, vpos_f, de_f, hsync_f, vsync_f, fs_f, rgb_f);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_m === 1'b1) begin
            while (q_m.size() > 0 && q_m[0].k <= k_m) begin
                mon_em = q_m.pop_front();
                if (mon_em.k < k_m) begin
                    tests++; fails++;
                    $display("FAIL %s: slot %0d missed (now %0d)", mon_em.name, mon_em.k, k_m);
                end else
                    check_entry(mon_em, hpos_m, vpos_m, de_m, hsync_m, vsync_m, fs_m, rgb_m);
            end
        end
    end

    // Line timing measurement on the full-size instance (first two lines)
    bit   meas_on = 1'b1;
    int   de_hi = 0, hs_lo = 0, de_rise1 = -1, de_rise2 = -1, hs_fall1 = -1;
    logic de_prev_f = 1'b0, hs_prev_f = 1'b1;
    always @(negedge clk) begin
        if (rst_f === 1'b1 && meas_on && k_f >= 1 && k_f <= 1601) begin
            if (k_f >= 2) begin
                if (de_f) de_hi++;
                if (!hsync_f) hs_lo++;
                if (de_f && !de_prev_f) begin
                    if (de_rise1 < 0) de_rise1 = k_f;
                    else if (de_rise2 < 0) de_rise2 = k_f;
                end
                if (!hsync_f && hs_prev_f && hs_fall1 < 0) hs_fall1 = k_f;
            end
            de_prev_f = de_f;
            hs_prev_f = hsync_f;
        end
    end

    // Frame measurement on the reduced instance
    int   fs_cnt = 0, fs_k = -1, vs_lo = 0, vs_fall = -1;
    logic vs_prev_m = 1'b1;
    always @(negedge clk) begin
        if (rst_m === 1'b1 && k_m >= 1) begin
            if (fs_m) begin fs_cnt++; if (fs_k < 0) fs_k = k_m; end
            if (!vsync_m) vs_lo++;
            if (!vsync_m && vs_prev_m && vs_fall < 0) vs_fall = k_m;
            vs_prev_m = vsync_m;
        end
    end

    task automatic wait_f(int target);
        int g;
        g = 0;
        while (k_f < target && g < 200000) begin @(negedge clk); g++; end
        check_int("wait_full_reached", (k_f >= target) ? 1 : 0, 1);
    endtask

    task automatic wait_m(int target);
        int g;
        g = 0;
        while (k_m < target && g < 200000) begin @(negedge clk); g++; end
        check_int("wait_mini_reached", (k_m >= target) ? 1 : 0, 1);
    endtask

    task automatic full_seq();
        exp_t e;
        wait_f(1700);
        check_int("f_de_high_2lines", de_hi, 1280);
        check_int("f_hsync_low_2lines", hs_lo, 192);
        check_int("f_hsync_after_de", hs_fall1 - de_rise1, 656);
        check_int("f_line_period", de_rise2 - de_rise1, 800);
        meas_on = 1'b0;
        // mid-line (h=98, v=2), outputs currently de=1 rgb=border
        #5 rst_f = 1'b0;
        #1;
        e = e_out(0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, "f_reset_immediate");
        check_entry(e, hpos_f, vpos_f, de_f, hsync_f, vsync_f, fs_f, rgb_f);
        repeat (3) @(negedge clk);
        push_f(e_out(1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, "f_rel_edge1"));
        of(0,   0, 1'b1, 1'b1, 1'b1, 1'b0, 12'h111, "f_rel_edge2_de");
        of(640, 0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, "f_rel_blank");
        rst_f = 1'b1;
        wait_f(700);
    endtask

    task automatic mini_seq();
        wait_m(41480);
        check_int("m_fs_pulses", fs_cnt, 1);
        check_int("m_fs_slot", fs_k, 136*HT_M + 2);
        check_int("m_vsync_low_len", vs_lo, 2*HT_M);
        check_int("m_vsync_after_fs", vs_fall - fs_k, 3*HT_M);
    endtask

    initial begin
        rst_f = 1'b0;
        rst_m = 1'b0;

        // full-size instance, lines 0..1 (all above the window -> border)
        of(0,   0, 1'b1, 1'b1, 1'b1, 1'b0, 12'h111, "f_first_pixel");
        of(639, 0, 1'b1, 1'b1, 1'b1, 1'b0, 12'h111, "f_last_visible");
        of(640, 0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, "f_first_blank");
        of(655, 0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, "f_pre_hsync");
        of(656, 0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, "f_hsync_first");
        of(751, 0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, "f_hsync_last");
        of(752, 0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, "f_post_hsync");
        of(799, 0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, "f_line_end");
        of(0,   1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h111, "f_line1_start");
        of(300, 1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h111, "f_line1_mid");
        af(64,  7'd0,   "f_hpos_64");
        af(67,  7'd0,   "f_hpos_67");
        af(68,  7'd1,   "f_hpos_68");
        af(575, 7'd127, "f_hpos_575");

        // reduced instance: window h 8..263, v 4..131, 2x2 per VRAM pixel
        am(8,   4,   7'd0,   6'd0,  "m_addr_first");
        am(263, 131, 7'd127, 6'd63, "m_addr_last");
        am(18,  10,  7'd5,   6'd3,  "m_addr_5_3");
        am(19,  11,  7'd5,   6'd3,  "m_addr_5_3_b");
        am(20,  10,  7'd6,   6'd3,  "m_addr_6_3");
        om(0,   0,   1'b1, 1'b1, 1'b1, 1'b0, 12'h111, "m_origin_border");
        om(7,   4,   1'b1, 1'b1, 1'b1, 1'b0, 12'h111, "m_left_edge");
        om(8,   4,   1'b1, 1'b1, 1'b1, 1'b0, 12'hFFF, "m_win_first");
        om(9,   5,   1'b1, 1'b1, 1'b1, 1'b0, 12'hFFF, "m_win_first_rep");
        om(10,  4,   1'b1, 1'b1, 1'b1, 1'b0, 12'h000, "m_win_px1");
        om(17,  10,  1'b1, 1'b1, 1'b1, 1'b0, 12'h000, "m_blk_left");
        om(18,  10,  1'b1, 1'b1, 1'b1, 1'b0, 12'hAAA, "m_blk_a");
        om(19,  10,  1'b1, 1'b1, 1'b1, 1'b0, 12'hAAA, "m_blk_b");
        om(18,  11,  1'b1, 1'b1, 1'b1, 1'b0, 12'hAAA, "m_blk_c");
        om(19,  11,  1'b1, 1'b1, 1'b1, 1'b0, 12'hAAA, "m_blk_d");
        om(20,  10,  1'b1, 1'b1, 1'b1, 1'b0, 12'h000, "m_blk_right");
        om(18,  9,   1'b1, 1'b1, 1'b1, 1'b0, 12'h000, "m_blk_above");
        om(18,  12,  1'b1, 1'b1, 1'b1, 1'b0, 12'h000, "m_blk_below");
        om(262, 130, 1'b1, 1'b1, 1'b1, 1'b0, 12'h555, "m_win_last_rep");
        om(263, 131, 1'b1, 1'b1, 1'b1, 1'b0, 12'h555, "m_win_last");
        om(264, 4,   1'b1, 1'b1, 1'b1, 1'b0, 12'h111, "m_right_edge");
        om(271, 4,   1'b1, 1'b1, 1'b1, 1'b0, 12'h111, "m_last_visible");
        om(272, 4,   1'b0, 1'b1, 1'b1, 1'b0, 12'h000, "m_blank_h");
        om(100, 3,   1'b1, 1'b1, 1'b1, 1'b0, 12'h111, "m_line_above");
        om(100, 132, 1'b1, 1'b1, 1'b1, 1'b0, 12'h111, "m_line_below");
        om(275, 0,   1'b0, 1'b1, 1'b1, 1'b0, 12'h000, "m_pre_hsync");
        om(276, 0,   1'b0, 1'b0, 1'b1, 1'b0, 12'h000, "m_hsync_first");
        om(283, 0,   1'b0, 1'b0, 1'b1, 1'b0, 12'h000, "m_hsync_last");
        om(284, 0,   1'b0, 1'b1, 1'b1, 1'b0, 12'h000, "m_post_hsync");
        om(0,   135, 1'b1, 1'b1, 1'b1, 1'b0, 12'h111, "m_last_line");
        om(0,   136, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, "m_frame_start");
        om(1,   136, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, "m_fs_one_clock");
        om(287, 138, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, "m_pre_vsync");
        om(0,   139, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, "m_vsync_first");
        om(287, 140, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, "m_vsync_last");
        om(0,   141, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, "m_post_vsync");
        om(287, 143, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, "m_frame_end");
        om(0,   144, 1'b1, 1'b1, 1'b1, 1'b0, 12'h111, "m_next_frame");

        repeat (3) @(negedge clk);
        rst_f = 1'b1;
        rst_m = 1'b1;

        fork
            full_seq();
            mini_seq();
        join

        repeat (2) @(negedge clk);
        while (q_f.size() > 0) begin
            tests++; fails++;
            $display("FAIL %s: never sampled (full)", q_f[0].name);
            void'(q_f.pop_front());
        end
        while (q_m.size() > 0) begin
            tests++; fails++;
            $display("FAIL %s: never sampled (mini)", q_m[0].name);
            void'(q_m.pop_front());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vram_scanout.md
# vram_scanout

Display back end for the 128x64, 2-bit-per-pixel VRAM that the CPU draws into. Generates 640x480@60 VGA timing on `clk` (25.175 MHz pixel clock) and reads VRAM through its read port one pixel per clock. Maps each 2-bit pixel through a 4-entry palette and drives registered sync, data-enable and RGB outputs. Also emits a once-per-frame pulse for the CPU's 60 Hz delay/sound timers.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- SCALE_LOG2, 2, upscale factor = 2^SCALE_LOG2, same in both axes
- X_OFFSET, 64, first visible column of the VRAM window
- Y_OFFSET, 112, first visible line of the VRAM window
- PAL0..PAL3, 12'h000 / 12'h555 / 12'hAAA / 12'hFFF, RGB444 colour for pixel values 0..3
- BORDER, 12'h111, colour for visible area outside the window
- clk  in  1  pixel clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- vram_rd_hpos  out  7  VRAM column address, 0..127
- vram_rd_vpos  out  6  VRAM row address, 0..63
- vram_rd_pixel  in  2  VRAM read data, valid exactly one clock after the address
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- de  out  1  high during the visible 640x480 area
- rgb  out  12  {R[3:0],G[3:0],B[3:0]}
- frame_start  out  1  one-clock pulse at the start of vertical blanking

## Operation
- Counters: h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of H params = 800). v_cnt 0..V_TOTAL-1 (525). h_cnt wraps to 0 and increments v_cnt. v_cnt wraps to 0 at V_TOTAL-1 when h_cnt also wraps.
- Stage 0 (counter values):
  - visible = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE
  - in_win = X_OFFSET<=h_cnt<X_OFFSET+(128<<SCALE_LOG2) && Y_OFFSET<=v_cnt<Y_OFFSET+(64<<SCALE_LOG2)
  - hs = !(H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC)
  - vs = !(V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC)
  - fs = (h_cnt==0 && v_cnt==V_ACTIVE)
- VRAM addresses are combinational from stage 0:
  - vram_rd_hpos = (h_cnt-X_OFFSET)>>SCALE_LOG2, truncated to 7 bits
  - vram_rd_vpos = (v_cnt-Y_OFFSET)>>SCALE_LOG2, truncated to 6 bits
  - Outside the window the address is don't-care; the returned data is discarded.
- Stage 1: visible, in_win, hs, vs and fs are registered alongside the outstanding read.
- Stage 2 (output registers):
  - de = visible
  - hsync = hs, vsync = vs, frame_start = fs
  - rgb = blank when !visible -> 0; in_win -> PALn, n = vram_rd_pixel; else BORDER
- VRAM contents may change at any time. The block does no tearing protection; each pixel shows whatever the read returns.
- Parameter rule: window must lie inside the active area. Out-of-range settings are unsupported and not checked.

## Timing
- Fixed latency: the counter state (h,v) appears on all outputs 2 clocks later. hsync, vsync, de, rgb and frame_start stay mutually aligned.
- Line = 800 clocks; frame = 420000 clocks. frame_start is high for 1 clock per frame.
- Reset assertion clears immediately, at any point in the frame:
  - h_cnt = 0, v_cnt = 0
  - all pipeline registers cleared
  - outputs: hsync=1, vsync=1, de=0, rgb=0, frame_start=0
- After reset deasserts, the first rising edge advances h_cnt to 1. Outputs for (0,0) appear 2 clocks after deassertion.
- Each window pixel is read SCALE² times per frame (2^SCALE_LOG2 × 2^SCALE_LOG2); there is no line buffer.

## Test plan
- Reset: hold reset_n low mid-line with counters nonzero -> outputs immediately hsync=1, vsync=1, de=0, rgb=0, frame_start=0. After release, de rises on the 2nd clock.
- Line timing: measure over two lines -> de high 640 clocks, hsync low 96 clocks starting 656 clocks after de rises, period 800.
- Frame timing: count between frame_start pulses -> 420000 clocks. vsync low for 1600 clocks starting 10 lines (8000 clocks) after frame_start.
- Address mapping: at h_cnt=64, v_cnt=112 -> vram_rd_hpos=0, vram_rd_vpos=0. At h_cnt=575, v_cnt=367 -> hpos=127, vpos=63.
- Palette/latency: VRAM model returns 2 for (5,3), 0 elsewhere -> rgb=12'hAAA on the 4x4 block of lines 124..127, columns 84..87, each appearing 2 clocks after the address. Window otherwise 12'h000, border 12'h111, blanking 0.
- Window edges: h_cnt=63 and h_cnt=576 on a window line -> rgb=BORDER. Line 111 and line 368 -> BORDER across the whole active line.
